mimo_ofdm_cp_remover: RTL

//   Front-end framer of the 2x2 MIMO-OFDM receiver, between sample sync and the 64-pt FFT.

---
 rtl/mimo_ofdm_cp_remover.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/mimo_ofdm_cp_remover.sv
`default_nettype none
// ============================================================================
// Module   : mimo_ofdm_cp_remover
// Purpose  : 2x2 MIMO-OFDM receive framer. Strips the cyclic prefix from the
//            dual-antenna sample stream and emits NFFT body samples per symbol.
// Revision : 1.0  initial release
// ============================================================================
module mimo_ofdm_cp_remover #(
    parameter int DATA_W  = 16,
    parameter int NFFT    = 64,
    parameter int NCP     = 16,
    parameter int BACKOFF = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    in_valid,
    input  logic                    sof_in,
    input  logic [DATA_W-1:0]       adc1_re,
    input  logic [DATA_W-1:0]       adc1_im,
    input  logic [DATA_W-1:0]       adc2_re,
    input  logic [DATA_W-1:0]       adc2_im,
    output logic                    out_valid,
    output logic                    out_sop,
    output logic                    out_eop,
    output logic [$clog2(NFFT)-1:0] out_idx,
    output logic [DATA_W-1:0]       out1_re,
    output logic [DATA_W-1:0]       out1_im,
    output logic [DATA_W-1:0]       out2_re,
    output logic [DATA_W-1:0]       out2_im,
    output logic                    out_abort,
    output logic [15:0]             sym_cnt
);

    localparam int IDX_W = $clog2(NFFT);
    localparam int CP_W  = $clog2(NCP + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CP   = 2'd1;
    localparam logic [1:0] S_BODY = 2'd2;

    // Last CP sample discarded; BACKOFF guard samples are kept as body
    localparam logic [CP_W-1:0]  c_CP_LAST   = CP_W'(NCP - BACKOFF - 1);
    localparam logic [IDX_W-1:0] c_BODY_LAST = IDX_W'(NFFT - 1);
    localparam logic [CP_W-1:0]  c_CP_ONE    = CP_W'(1);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [CP_W-1:0]  r_cp_cnt;
    logic [CP_W-1:0]  w_cp_cnt_nxt;
    logic [IDX_W-1:0] r_body_cnt;
    logic [IDX_W-1:0] w_body_cnt_nxt;

    logic w_accept;
    logic w_body_last;
    logic w_fwd;
    logic w_abort;

    assign w_accept    = in_valid & enable;
    assign w_body_last = (r_body_cnt == c_BODY_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cp_cnt   <= '0;
            r_body_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cp_cnt   <= w_cp_cnt_nxt;
            r_body_cnt <= w_body_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cp_cnt_nxt   = r_cp_cnt;
        w_body_cnt_nxt = r_body_cnt;
        if (!enable) begin
            w_state_nxt    = S_IDLE;
            w_cp_cnt_nxt   = '0;
            w_body_cnt_nxt = '0;
        end else if (in_valid) begin
            // A strobe always restarts framing, whatever the current state
            if (sof_in) begin
                if (c_CP_LAST == '0) begin
                    w_state_nxt    = S_BODY;
                    w_body_cnt_nxt = '0;
                end else begin
                    w_state_nxt  = S_CP;
                    w_cp_cnt_nxt = c_CP_ONE;
                end
            end else begin
                case (r_state)
                    S_IDLE: w_state_nxt = S_IDLE;
                    S_CP: begin
                        if (r_cp_cnt == c_CP_LAST) begin
                            w_state_nxt    = S_BODY;
                            w_body_cnt_nxt = '0;
                        end else begin
                            w_cp_cnt_nxt = r_cp_cnt + c_CP_ONE;
                        end
                    end
                    S_BODY: begin
                        if (w_body_last) begin
                            w_state_nxt  = S_CP;
                            w_cp_cnt_nxt = '0;
                        end else begin
                            w_body_cnt_nxt = r_body_cnt + IDX_W'(1);
                        end
                    end
                    default: w_state_nxt = S_IDLE;
                endcase
            end
        end
    end

    // A strobe on the final body sample still completes that symbol
    always_comb begin
        w_fwd   = w_accept && (r_state == S_BODY) && (!sof_in || w_body_last);
        w_abort = (r_state == S_BODY) && (r_body_cnt != '0) &&
                  (!enable || (in_valid && sof_in && !w_body_last));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
            out_idx   <= '0;
            out1_re   <= '0;
            out1_im   <= '0;
            out2_re   <= '0;
            out2_im   <= '0;
            out_abort <= 1'b0;
            sym_cnt   <= '0;
        end else begin
            out_valid <= w_fwd;
            out_sop   <= w_fwd && (r_body_cnt == '0);
            out_eop   <= w_fwd && w_body_last;
            out_abort <= w_abort;
            if (w_fwd) begin
                out_idx <= r_body_cnt;
                out1_re <= adc1_re;
                out1_im <= adc1_im;
                out2_re <= adc2_re;
                out2_im <= adc2_im;
            end
            if (w_fwd && w_body_last) begin
                sym_cnt <= sym_cnt + 16'd1;
            end
        end
    end

endmodule
`default_nettype wire
